de_zone_hub: RTL
================

# de_zone_hub

Parametrised horizontal-zone duty hub for the dynamic backlight dimming path. Tracks the active pixel position inside each DE-high line, maps it to one of ZONES equal-width backlight zones and drives a one-hot duty vector. A zone bit is set only while the block duty count is within a mode-selected threshold. It is the configurable successor of the fixed 24×80 hub and adds line-length checking, selectable thresholds and optional duty statistics.

## Interface
- ZONES, 24: number of horizontal zones (2..32)
- ZONE_W, 80: active pixels per zone (2..255)
- DUTY_W, 7: width of block duty count
- CNT_W, 12: width of statistics counter; must hold ZONES*ZONE_W
- iODCK  in  1  pixel clock
- iRST  in  1  synchronous, active-high reset
- iDE  in  1  data enable; high = active pixel this cycle
- iH_Block_Duty_Count  in  DUTY_W  current block duty count
- iDutySW  in  2  threshold select
- oH_Duty  out  ZONES  one-hot zone duty vector
- oZone  out  $clog2(ZONES)  zone index of last accepted pixel
- oLineDone  out  1  one-cycle pulse: full line received
- oShortLine  out  1  one-cycle pulse: DE fell before line end
- oOverrun  out  1  sticky: DE stayed high past ZONES*ZONE_W pixels

## Operation
- Threshold by iDutySW: 00→79, 01→64, 10→48, 11→32. Compared values are zero-extended to DUTY_W. outen = (iH_Block_Duty_Count <= threshold).
- States:
  - IDLE: oH_Duty=0. On iDE=1, pixel 0 of zone 0 is accepted and the state goes to ACTIVE.
  - ACTIVE: each iDE=1 cycle accepts one pixel and advances pix_cnt 0..ZONE_W-1. On wrap, pix_cnt returns to 0 and zone increments.
    - Accepting pixel ZONE_W-1 of zone ZONES-1 → DONE.
    - iDE=0 in ACTIVE → IDLE and pulse oShortLine.
  - DONE: oLineDone pulses on entry.
    - iDE=0 → IDLE.
    - iDE=1 → OVER and set oOverrun.
  - OVER: oH_Duty=0. Remains until iDE=0, then IDLE.
- oH_Duty: the bit for the accepted pixel's zone equals outen sampled in the same cycle. All other bits are 0. When no pixel is accepted, the vector is 0.
- oOverrun clears only on iRST.
- iDutySW may change at any time. It takes effect on the next accepted pixel.

## Timing
- Every output is registered. Reset values: oH_Duty=0, oZone=0, oLineDone=0, oShortLine=0, oOverrun=0, state=IDLE, counters=0.
- Latency is 1 cycle: a pixel accepted at edge t appears on oH_Duty/oZone after edge t+1.
- oLineDone is asserted in the cycle after the last pixel is accepted, coincident with that pixel's oH_Duty.
- oShortLine is asserted in the cycle after the first iDE=0 seen in ACTIVE.
- DE gap and new line on back-to-back cycles: DE low for a single cycle after DONE returns to IDLE. A new line may start on the next cycle.
- iRST mid-line has priority over everything. The next cycle shows reset values, and the partial line produces no pulses.
- oZone holds its last value while idle.

## Configuration
- DE_ZONE_HUB_STATS_EN defined:
  - Adds output oOnCount [CNT_W-1:0], which counts accepted pixels with outen=1 in the current line.
  - Its value is latched to the output when oLineDone pulses and is held until the next oLineDone or iRST (reset value 0).
  - The internal count clears at line start. A short line does not update oOnCount.
- Undefined: the port and its counter are absent. All other behaviour is identical.

## Structure
- Package de_zone_pkg holds:
  - the state enum (IDLE, ACTIVE, DONE, OVER);
  - the four threshold constants (79, 64, 48, 32);
  - a function mapping iDutySW to threshold.
- Sub-module de_zone_counter holds the pix_cnt/zone counter. It has inputs advance and clear, and outputs zone, pix_cnt and last (last pixel of last zone). The top holds the FSM, compare and output registers.

## Test plan
- Defaults, iDutySW=01, duty=10, DE high for 1920 cycles:
  - oH_Duty walks 24'h000001…24'h800000, holding 80 cycles each.
  - oLineDone is a single pulse with oH_Duty=24'h800000.
- iDutySW=00, duty=80 for pixels 0..159, then 70: oH_Duty=0 for zones 0–1 and one-hot from zone 2 onward.
- DE falls after 500 pixels: oShortLine pulses once, oH_Duty=0 next cycle, no oLineDone.
- DE high for 1925 cycles: oLineDone pulses, oH_Duty=0 for the extra pixels, oOverrun=1 until iRST.
- iRST asserted at pixel 900: all outputs 0 next cycle. A fresh 1920-pixel line then completes normally.
- STATS_EN, ZONES=4, ZONE_W=8, duty≤threshold on 20 of 32 pixels: oOnCount=20 at oLineDone, held through the next short line.

Source files
------------

// File: rtl/de_zone_hub_pkg.sv
// Shared types and threshold table for the horizontal-zone duty hub.
package de_zone_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2,
        OVER   = 2'd3
    } HubState;

    localparam int unsigned TH_W = 7;

    localparam logic [TH_W-1:0] TH_SW0 = 7'd79;
    localparam logic [TH_W-1:0] TH_SW1 = 7'd64;
    localparam logic [TH_W-1:0] TH_SW2 = 7'd48;
    localparam logic [TH_W-1:0] TH_SW3 = 7'd32;

    // Duty threshold selected by the two-bit switch.
    function automatic logic [TH_W-1:0] thresholdOf(input logic [1:0] sw);
        logic [TH_W-1:0] th;
        case (sw)
            2'b00:   th = TH_SW0;
            2'b01:   th = TH_SW1;
            2'b10:   th = TH_SW2;
            default: th = TH_SW3;
        endcase
        return th;
    endfunction

endpackage

// File: rtl/de_zone_hub_if.sv
// Pixel-side bus of the zone duty hub; oOnCount exists only with DE_ZONE_HUB_STATS_EN.
interface de_zone_hub_if #(
    parameter int unsigned ZONES  = 24,
    parameter int unsigned DUTY_W = 7
`ifdef DE_ZONE_HUB_STATS_EN
    , parameter int unsigned CNT_W = 12
`endif
);

    logic                       iDE;
    logic [DUTY_W-1:0]          iH_Block_Duty_Count;
    logic [1:0]                 iDutySW;
    logic [ZONES-1:0]           oH_Duty;
    logic [$clog2(ZONES)-1:0]   oZone;
    logic                       oLineDone;
    logic                       oShortLine;
    logic                       oOverrun;
`ifdef DE_ZONE_HUB_STATS_EN
    logic [CNT_W-1:0]           oOnCount;

    modport master (
        output iDE, iH_Block_Duty_Count, iDutySW,
        input  oH_Duty, oZone, oLineDone, oShortLine, oOverrun, oOnCount
    );

    modport slave (
        input  iDE, iH_Block_Duty_Count, iDutySW,
        output oH_Duty, oZone, oLineDone, oShortLine, oOverrun, oOnCount
    );
`else
    modport master (
        output iDE, iH_Block_Duty_Count, iDutySW,
        input  oH_Duty, oZone, oLineDone, oShortLine, oOverrun
    );

    modport slave (
        input  iDE, iH_Block_Duty_Count, iDutySW,
        output oH_Duty, oZone, oLineDone, oShortLine, oOverrun
    );
`endif

endinterface

// File: rtl/de_zone_hub_counter.sv
// Pixel-within-zone and zone counter; wraps to the origin after the last pixel of the last zone.
module de_zone_counter #(
    parameter int unsigned ZONES  = 24,
    parameter int unsigned ZONE_W = 80
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       advance,
    input  logic                       clear,
    output logic [$clog2(ZONES)-1:0]   zone,
    output logic [$clog2(ZONE_W)-1:0]  pixCnt,
    output logic                       last
);

    localparam int unsigned ZONE_IW = $clog2(ZONES);
    localparam int unsigned PIX_W   = $clog2(ZONE_W);

    logic zoneEnd;

    assign zoneEnd = (pixCnt == PIX_W'(ZONE_W - 1));
    assign last    = zoneEnd && (zone == ZONE_IW'(ZONES - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pixCnt <= '0;
            zone   <= '0;
        end else if (advance) begin
            if (zoneEnd) begin
                pixCnt <= '0;
                zone   <= last ? '0 : zone + ZONE_IW'(1);
            end else begin
                pixCnt <= pixCnt + PIX_W'(1);
            end
        end
    end

endmodule

// File: rtl/de_zone_hub.sv
// Horizontal-zone duty hub: maps DE-high pixels to zones and drives a one-hot duty vector.
// Optional per-line duty statistics are enabled by defining DE_ZONE_HUB_STATS_EN.
module de_zone_hub
    import de_zone_pkg::*;
#(
    parameter int unsigned ZONES  = 24,
    parameter int unsigned ZONE_W = 80,
    parameter int unsigned DUTY_W = 7
`ifdef DE_ZONE_HUB_STATS_EN
    , parameter int unsigned CNT_W = 12
`endif
) (
    input  logic          iODCK,
    input  logic          iRST,
    de_zone_hub_if.slave  bus
);

    localparam int unsigned ZONE_IW = $clog2(ZONES);
    localparam int unsigned PIX_W   = $clog2(ZONE_W);
    localparam int unsigned CMP_W   = (DUTY_W > TH_W) ? DUTY_W : TH_W;

    HubState              state;
    HubState              stateNext;
    logic                 accept;
    logic                 clear;
    logic                 shortNext;
    logic                 overSet;
    logic                 outen;
    logic [ZONES-1:0]     dutyNext;
    logic [ZONE_IW-1:0]   zone;
    logic [PIX_W-1:0]     pixCnt;
    logic                 last;

    de_zone_counter #(
        .ZONES  (ZONES),
        .ZONE_W (ZONE_W)
    ) uCounter (
        .clk     (iODCK),
        .rst     (iRST),
        .advance (accept),
        .clear   (clear),
        .zone    (zone),
        .pixCnt  (pixCnt),
        .last    (last)
    );

    assign outen = (CMP_W'(bus.iH_Block_Duty_Count) <= CMP_W'(thresholdOf(bus.iDutySW)));

    always_ff @(posedge iODCK) begin
        if (iRST) state <= IDLE;
        else      state <= stateNext;
    end

    // Next state plus the decisions that feed the output registers.
    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        clear     = 1'b0;
        shortNext = 1'b0;
        overSet   = 1'b0;
        dutyNext  = '0;
        case (state)
            IDLE: begin
                if (bus.iDE) begin
                    accept    = 1'b1;
                    stateNext = ACTIVE;
                end
            end
            ACTIVE: begin
                if (bus.iDE) begin
                    accept = 1'b1;
                    if (last) stateNext = DONE;
                end else begin
                    clear     = 1'b1;
                    shortNext = 1'b1;
                    stateNext = IDLE;
                end
            end
            DONE: begin
                if (bus.iDE) begin
                    overSet   = 1'b1;
                    stateNext = OVER;
                end else begin
                    stateNext = IDLE;
                end
            end
            OVER: begin
                if (!bus.iDE) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        if (accept && outen) dutyNext = ZONES'(1) << zone;
    end

    always_ff @(posedge iODCK) begin
        if (iRST) begin
            bus.oH_Duty    <= '0;
            bus.oZone      <= '0;
            bus.oLineDone  <= 1'b0;
            bus.oShortLine <= 1'b0;
            bus.oOverrun   <= 1'b0;
        end else begin
            bus.oH_Duty    <= dutyNext;
            bus.oLineDone  <= accept && last;
            bus.oShortLine <= shortNext;
            if (accept)  bus.oZone    <= zone;
            if (overSet) bus.oOverrun <= 1'b1;
        end
    end

`ifdef DE_ZONE_HUB_STATS_EN
    logic [CNT_W-1:0] onCnt;
    logic [CNT_W-1:0] onCntNext;

    // A pixel accepted from IDLE starts a new line, so the running count restarts there.
    assign onCntNext = ((state == IDLE) ? '0 : onCnt) + CNT_W'(outen);

    always_ff @(posedge iODCK) begin
        if (iRST) begin
            onCnt        <= '0;
            bus.oOnCount <= '0;
        end else if (accept) begin
            onCnt <= onCntNext;
            if (last) bus.oOnCount <= onCntNext;
        end
    end
`endif

    idleAtOrigin: assert property (@(posedge iODCK) disable iff (iRST)
        (state == IDLE) |-> (pixCnt == '0 && zone == '0));

endmodule
